// File: rtl/a2_bus_host.sv
// a2_bus_host: Apple II slot-bus initiator clocked from C7M.
// Drives PHI1/PHI0 phase timing, the 6502 address bus, R/W, the slot
// selects and the data bus for one host request per bus cycle.
// Optional feature macro: A2_LONG_CYCLE_EN (every 65th bus cycle is
// stretched to 8 clocks by inserting phase P7 between P5 and P6).
module a2_bus_host (
  input  logic        C7M,
  input  logic        nRES,
  input  logic [3:0]  SLOT,
  input  logic        req,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic [7:0]  req_wdata,
  output logic        req_ready,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        PHI1,
  output logic        PHI0,
  output logic [15:0] A,
  output logic        nWE,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        nDEVSEL,
  output logic        nIOSEL,
  output logic        nIOSTRB
);

  typedef enum logic [2:0] {
    P0 = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3,
    P4 = 3'd4, P5 = 3'd5, P6 = 3'd6, P7 = 3'd7
  } phase_t;

  phase_t      phase, phase_nxt;
  logic        active, active_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic        we_q, we_nxt;
  logic [7:0]  wdata_q, wdata_nxt;
  logic        long_now;

  logic        phi1_nxt;
  logic        sel_win;
  logic        dev_hit, io_hit, strb_hit;
  logic        oe_nxt;
  logic [7:0]  dout_nxt;
  logic [15:0] a_nxt;
  logic        nwe_nxt;
  logic        done_nxt;
  logic [7:0]  rdata_nxt;

`ifdef A2_LONG_CYCLE_EN
  logic [6:0] cycle_cnt;

  assign long_now = (cycle_cnt == 7'd64);

  // Bus-cycle counter 0..64; advances on the edge that ends each bus cycle.
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      cycle_cnt <= 7'd0;
    end else if (phase == P6) begin
      cycle_cnt <= long_now ? 7'd0 : cycle_cnt + 7'd1;
    end
  end
`else
  assign long_now = 1'b0;
`endif

  assign req_ready = (phase == P6);

  // Phase sequencing, request acceptance and next values of every registered output.
  always_comb begin
    phase_nxt  = phase;
    active_nxt = active;
    addr_nxt   = addr_q;
    we_nxt     = we_q;
    wdata_nxt  = wdata_q;
    done_nxt   = 1'b0;
    rdata_nxt  = rdata;

    case (phase)
      P0: phase_nxt = P1;
      P1: phase_nxt = P2;
      P2: phase_nxt = P3;
      P3: phase_nxt = P4;
      P4: phase_nxt = P5;
      P5: phase_nxt = long_now ? P7 : P6;
      P7: phase_nxt = P6;
      P6: begin
        phase_nxt  = P0;
        done_nxt   = active;
        if (active && !we_q) begin
          rdata_nxt = D_in;
        end
        active_nxt = req;
        if (req) begin
          addr_nxt  = req_addr;
          we_nxt    = req_we;
          wdata_nxt = req_wdata;
        end
      end
    endcase

    phi1_nxt = (phase_nxt == P0) || (phase_nxt == P1) || (phase_nxt == P2);
    sel_win  = active_nxt && !phi1_nxt;

    dev_hit  = (addr_nxt[15:4]  == (12'hC08 + {8'h00, SLOT}));
    io_hit   = (addr_nxt[15:8]  == (8'hC0 + {4'h0, SLOT}));
    strb_hit = (addr_nxt[15:11] == 5'b11001);

    oe_nxt   = active_nxt && we_nxt && !phi1_nxt && (phase_nxt != P3);
    dout_nxt = oe_nxt ? wdata_nxt : 8'h00;
    a_nxt    = active_nxt ? addr_nxt : 16'h0000;
    nwe_nxt  = !(active_nxt && we_nxt);
  end

  // State register plus registered bus outputs; reset forces an idle P0.
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      phase   <= P0;
      active  <= 1'b0;
      addr_q  <= 16'h0000;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      PHI1    <= 1'b1;
      PHI0    <= 1'b0;
      A       <= 16'h0000;
      nWE     <= 1'b1;
      D_out   <= 8'h00;
      D_oe    <= 1'b0;
      nDEVSEL <= 1'b1;
      nIOSEL  <= 1'b1;
      nIOSTRB <= 1'b1;
      done    <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      phase   <= phase_nxt;
      active  <= active_nxt;
      addr_q  <= addr_nxt;
      we_q    <= we_nxt;
      wdata_q <= wdata_nxt;
      PHI1    <= phi1_nxt;
      PHI0    <= !phi1_nxt;
      A       <= a_nxt;
      nWE     <= nwe_nxt;
      D_out   <= dout_nxt;
      D_oe    <= oe_nxt;
      nDEVSEL <= !(sel_win && dev_hit);
      nIOSEL  <= !(sel_win && io_hit);
      nIOSTRB <= !(sel_win && strb_hit);
      done    <= done_nxt;
      rdata   <= rdata_nxt;
    end
  end

endmodule

// File: doc/a2_bus_host.md
# a2_bus_host

Synthesizable Apple II slot-bus initiator clocked from the 7M clock. It generates PHI1/PHI0 machine-cycle timing, the 6502 address bus, R/W, the slot select strobes (nDEVSEL, nIOSEL, nIOSTRB) and the data bus, for one request at a time from a simple host-side request port. It is the motherboard-side driver for bench and FPGA-harness use, so slot cards can be exercised against real phase timing.

## Interface
- SLOT, 4, slot number 1..7; selects the nDEVSEL/nIOSEL decode.
- C7M  in  1  7M clock; all logic on rising edge.
- nRES  in  1  asynchronous, active-low reset.
- req  in  1  request valid; fields below must be stable while req high.
- req_addr  in  16  6502 address.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  8  write data.
- req_ready  out  1  combinational; high while P==6; a request is accepted on a rising edge where req & req_ready.
- done  out  1  one-clock pulse after each accepted transaction's bus cycle ends.
- rdata  out  8  captured read data; valid with done on reads; holds its value otherwise.
- PHI1, PHI0  out  1  bus phases.
- A  out  16  address bus.
- nWE  out  1  6502 R/W (low = write).
- D_out  out  8  data driven to bus; D_oe out 1 enables the driver.
- D_in  in  8  data bus as seen from the slot.
- nDEVSEL, nIOSEL, nIOSTRB  out  1  active-low slot selects.

## Operation
- Phase counter P (3 bits) advances every clock: 0,1,2,3,4,5,6,0…; P=7 occurs only in long cycles (see Configuration).
- One bus cycle is one pass of P. PHI1=1 for P∈{0,1,2}; PHI0=1 for P∈{3,4,5,6,7}. PHI0 and PHI1 are never both high.
- Acceptance: on the edge leaving P=6, if req is high, {addr, we, wdata} are latched, and the following bus cycle carries the transaction. Otherwise the following cycle is idle.
- Idle cycle: A=16'h0000, nWE=1, D_oe=0, all selects high.
- Transaction cycle: A and nWE are driven for the whole cycle (P=0..6). They update on the edge entering P=0.
- Selects are asserted only during PHI0 (P=3..7), decoded from the latched address:
  - nDEVSEL: A[15:4] == 12'hC08 + SLOT.
  - nIOSEL: A[15:8] == 8'hC0 + SLOT.
  - nIOSTRB: A[15:11] == 5'b11001 ($C800–$CFFF), independent of SLOT.
  - All other addresses: no select asserted.
- Writes: D_oe=1 and D_out=wdata for P∈{4,5,6,7}; D_oe=0 elsewhere.
- Reads: D_in is sampled into rdata on the edge leaving P=6 (the final PHI0 clock).
- done: high for the single clock following that edge, for both reads and writes. A write leaves rdata unchanged.
- Back-to-back: holding req high with new fields after each acceptance gives one transaction per bus cycle. Acceptance of request N+1 occurs on the same edge that completes request N.

## Timing
- Reset values: P=0, PHI1=1, PHI0=0, A=0, nWE=1, D_oe=0, D_out=0, selects=1, done=0, rdata=0. req_ready=0 (follows from P=0).
- All outputs except req_ready are registered.
- Latency: accept edge → done rises 7 clocks later (8 if long cycle), and is high for 1 clock.
- Selects fall on the edge entering P=3 and rise on the edge entering P=0.
- Reset mid-cycle: all outputs return to reset values immediately. An in-flight transaction is dropped and produces no done. The first cycle after release is idle.
- req arriving at any P≠6 waits; there is no queueing beyond the single latched request.

## Configuration
- A2_LONG_CYCLE_EN defined:
  - A 7-bit cycle counter (0..64, wrapping) counts bus cycles.
  - Cycle 64 inserts P=7 between P=5 and P=6, so PHI0 lasts 5 clocks and the cycle 8 clocks.
  - Selects and D_oe stay asserted through P=7. A transaction falling in cycle 64 completes 8 clocks after acceptance.
  - The counter resets to 0.
- Undefined: every cycle is 7 clocks, the counter is absent, and P=7 is unreachable.

## Test plan
- Reset/clocking: hold nRES low → reset values above. After release: PHI1 high 3 clocks, PHI0 high 4, period 7, never overlapping.
- Read $C0C3, SLOT=4, D_in=8'h5A → nDEVSEL low exactly P3–P6, nIOSEL/nIOSTRB high, nWE=1, done 7 clocks after accept, rdata=8'h5A.
- Write $C0C0 data 8'h12 → nWE=0 for P0–P6, D_oe=1 and D_out=8'h12 only P4–P6, nDEVSEL low P3–P6, done after 7 clocks, rdata unchanged.
- Decode sweep, SLOT=4:
  - $C400 → only nIOSEL.
  - $CFFF → only nIOSTRB.
  - $C0B0 and $C000 → no select.
  - Repeat with SLOT=6: $C0E5 → nDEVSEL; $C600 → nIOSEL.
- Back-to-back: reads $C0C0, $C0C1, $C0C2 presented consecutively with req held → accepted at three successive P=6 edges, done every 7 clocks, rdata matches D_in per cycle.
- Boundaries:
  - With A2_LONG_CYCLE_EN, the 65th cycle is 8 clocks with PHI0 5 clocks; without it, all cycles are 7.
  - Assert nRES at P=4 of a write → D_oe and selects drop immediately, and no done is produced.
